// File: rtl/run_monitor.sv
// run_monitor: sequences core reset, counts RUN cycles and per-core retired
// instructions, captures each core's result on its first trap and judges the
// run as pass, fail or timeout. Every output is driven straight from a register.
module run_monitor #(
  parameter int          NCORES     = 1,
  parameter int          DATA_W     = 32,
  parameter int          CNT_W      = 32,
  parameter int          RST_CYCLES = 4,
  parameter int          TIMEOUT    = 5000,
  parameter int unsigned PASS_VAL   = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [NCORES-1:0]        retire,
  input  logic [NCORES-1:0]        trap,
  input  logic [NCORES*DATA_W-1:0] result,
  output logic [NCORES-1:0]        core_rst_n,
  output logic [1:0]               state,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [NCORES-1:0]        trap_mask,
  output logic [NCORES-1:0]        fail_mask,
  output logic [CNT_W-1:0]         cycles,
  output logic [NCORES*CNT_W-1:0]  retired,
  output logic [NCORES*DATA_W-1:0] result_q
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] PASS_W   = DATA_W'(PASS_VAL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   state_r,      state_s;
  logic [RC_W-1:0]          rst_cnt_r,    rst_cnt_s;
  logic [CNT_W-1:0]         cycles_r,     cycles_s;
  logic [NCORES*CNT_W-1:0]  retired_r,    retired_s;
  logic [NCORES-1:0]        trap_mask_r,  trap_mask_s;
  logic [NCORES-1:0]        fail_mask_r,  fail_mask_s;
  logic [NCORES*DATA_W-1:0] result_q_r,   result_q_s;
  logic                     done_r,       done_s;
  logic                     pass_r,       pass_s;
  logic                     timeout_r,    timeout_s;
  logic [NCORES-1:0]        core_rst_n_r, core_rst_n_s;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Next-state, counter, capture and verdict logic for the whole run sequence.
  always_comb begin
    state_s     = state_r;
    rst_cnt_s   = rst_cnt_r;
    cycles_s    = cycles_r;
    retired_s   = retired_r;
    trap_mask_s = trap_mask_r;
    fail_mask_s = fail_mask_r;
    result_q_s  = result_q_r;
    done_s      = done_r;
    pass_s      = pass_r;
    timeout_s   = timeout_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        // A new run starts from a clean slate; otherwise everything is frozen.
        if (start) begin
          state_s     = ST_RESET;
          rst_cnt_s   = '0;
          cycles_s    = '0;
          retired_s   = '0;
          trap_mask_s = '0;
          fail_mask_s = '0;
          result_q_s  = '0;
          done_s      = 1'b0;
          pass_s      = 1'b0;
          timeout_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RESET: begin
        if (rst_cnt_r == RC_LAST) begin
          state_s   = ST_RUN;
          rst_cnt_s = '0;
        end else begin
          rst_cnt_s = rst_cnt_r + {{(RC_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        cycles_s = sat_inc(cycles_r);
        for (int i = 0; i < NCORES; i++) begin
          // Retires count up to and including the cycle of the first trap.
          if (retire[i] && !trap_mask_r[i]) begin
            retired_s[i*CNT_W +: CNT_W] = sat_inc(retired_r[i*CNT_W +: CNT_W]);
          end else begin
            retired_s[i*CNT_W +: CNT_W] = retired_r[i*CNT_W +: CNT_W];
          end
          // Only the first trap of a core is captured; later levels are ignored.
          if (trap[i] && !trap_mask_r[i]) begin
            trap_mask_s[i]                = 1'b1;
            result_q_s[i*DATA_W +: DATA_W] = result[i*DATA_W +: DATA_W];
            fail_mask_s[i]                = (result[i*DATA_W +: DATA_W] != PASS_W);
          end else begin
            trap_mask_s[i] = trap_mask_r[i];
          end
        end
        // Completion by trap takes priority over the budget running out.
        if (&trap_mask_s) begin
          state_s   = ST_DONE;
          done_s    = 1'b1;
          pass_s    = ~|fail_mask_s;
          timeout_s = 1'b0;
        end else if (cycles_s == TO_VAL) begin
          state_s   = ST_DONE;
          done_s    = 1'b1;
          pass_s    = 1'b0;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Cores run only in RUN, and a trapped core is parked back in reset.
    if (state_s == ST_RUN) begin
      core_rst_n_s = ~trap_mask_s;
    end else begin
      core_rst_n_s = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      rst_cnt_r    <= '0;
      cycles_r     <= '0;
      retired_r    <= '0;
      trap_mask_r  <= '0;
      fail_mask_r  <= '0;
      result_q_r   <= '0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      timeout_r    <= 1'b0;
      core_rst_n_r <= '0;
    end else begin
      state_r      <= state_s;
      rst_cnt_r    <= rst_cnt_s;
      cycles_r     <= cycles_s;
      retired_r    <= retired_s;
      trap_mask_r  <= trap_mask_s;
      fail_mask_r  <= fail_mask_s;
      result_q_r   <= result_q_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      timeout_r    <= timeout_s;
      core_rst_n_r <= core_rst_n_s;
    end
  end

  assign state      = state_r;
  assign core_rst_n = core_rst_n_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign timeout    = timeout_r;
  assign trap_mask  = trap_mask_r;
  assign fail_mask  = fail_mask_r;
  assign cycles     = cycles_r;
  assign retired    = retired_r;
  assign result_q   = result_q_r;

endmodule
